dmem_access_arbiter: RTL and testbench

//  Shares the single-port 64-bit data memory between the fetch requester (F, read-only)
//  and the memory-stage requester (D, read/write) of the Y86-64 processor. Arbitrates

---
 rtl/dmem_access_arbiter_if.sv | 49 ++++
 rtl/dmem_access_arbiter.sv | 112 +++++++++++
 tb/tb_dmem_access_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_arbiter_if.sv
// Bus bundle between the F/D requesters, the data-memory arbiter and the memory port.
// The arbiter uses the slave view; the requester/memory side uses the master view.
interface dmem_access_arbiter_if #(
   parameter int AW = 13
);
   localparam int DATA_W = 64;

   logic              d_req;
   logic              d_we;
   logic [63:0]       d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;
   logic              d_err;

   logic              f_req;
   logic [63:0]       f_addr;
   logic              f_ack;
   logic [DATA_W-1:0] f_rdata;
   logic              f_err;

   logic              mem_en;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   modport slave (
      input  d_req, d_we, d_addr, d_wdata,
      output d_ack, d_rdata, d_err,
      input  f_req, f_addr,
      output f_ack, f_rdata, f_err,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output busy
   );

   modport master (
      output d_req, d_we, d_addr, d_wdata,
      input  d_ack, d_rdata, d_err,
      output f_req, f_addr,
      input  f_ack, f_rdata, f_err,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  busy
   );
endinterface

// File: rtl/dmem_access_arbiter.sv
// Round-robin arbiter sharing the single-port 64-bit data memory between fetch (F, read-only)
// and memory stage (D, read/write); range-checks addresses and sequences the 1-cycle read latency.
module dmem_access_arbiter #(
   parameter int MEM_WORDS = 8192,
   parameter int AW        = 13
) (
   input logic                   clk,
   input logic                   rst_n,
   dmem_access_arbiter_if.slave  bus
);
   localparam int          DATA_W    = 64;
   localparam logic [63:0] MEM_LIMIT = 64'(MEM_WORDS);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      ACK
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic              last_d;
   logic              gnt_d;
   logic              lat_we;
   logic              lat_err;
   logic [AW-1:0]     lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [DATA_W-1:0] d_rdata_q;
   logic [DATA_W-1:0] f_rdata_q;

   logic              any_req;
   logic              take_d;
   logic [63:0]       sel_addr;
   logic              sel_err;

   // On a tie, D wins unless D was the previous grant.
   assign any_req  = bus.d_req | bus.f_req;
   assign take_d   = bus.d_req & (~bus.f_req | ~last_d);
   assign sel_addr = take_d ? bus.d_addr : bus.f_addr;
   assign sel_err  = (sel_addr >= MEM_LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_nxt = sel_err ? ACK : ISSUE;
            end
         end
         ISSUE:   state_nxt = CAPTURE;
         CAPTURE: state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_d    <= 1'b0;
         gnt_d     <= 1'b0;
         lat_we    <= 1'b0;
         lat_err   <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         d_rdata_q <= '0;
         f_rdata_q <= '0;
      end else begin
         if (state == IDLE && any_req) begin
            gnt_d     <= take_d;
            last_d    <= take_d;
            lat_we    <= take_d & bus.d_we;
            lat_err   <= sel_err;
            lat_addr  <= sel_addr[AW-1:0];
            lat_wdata <= take_d ? bus.d_wdata : '0;
         end
         // Memory data is valid the cycle after the enable; error accesses never get here.
         if (state == CAPTURE && !lat_we) begin
            if (gnt_d) begin
               d_rdata_q <= bus.mem_rdata;
            end else begin
               f_rdata_q <= bus.mem_rdata;
            end
         end
      end
   end

   assign bus.mem_en    = (state == ISSUE);
   assign bus.mem_we    = (state == ISSUE) & lat_we;
   assign bus.mem_addr  = lat_addr;
   assign bus.mem_wdata = lat_wdata;

   assign bus.d_ack   = (state == ACK) & gnt_d;
   assign bus.d_err   = (state == ACK) & gnt_d & lat_err;
   assign bus.d_rdata = d_rdata_q;

   assign bus.f_ack   = (state == ACK) & ~gnt_d;
   assign bus.f_err   = (state == ACK) & ~gnt_d & lat_err;
   assign bus.f_rdata = f_rdata_q;

   assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Scoreboard bench for dmem_access_arbiter: drivers push expected responses from a word-level
// memory model; a negedge monitor pops them on every ack and compares.
module tb_dmem_access_arbiter;
   localparam int MEM_WORDS = 8192;
   localparam int AW        = 13;

   typedef struct packed {
      logic        err;
      logic [63:0] rdata;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always #5 clk = ~clk;

   dmem_access_arbiter_if #(.AW(AW)) bus ();

   dmem_access_arbiter #(.MEM_WORDS(MEM_WORDS), .AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t        dq[$];
   exp_t        fq[$];
   logic [63:0] ref_mem [0:MEM_WORDS-1];
   logic [63:0] tmem    [0:MEM_WORDS-1];
   logic [63:0] last_d  = '0;
   logic [63:0] last_f  = '0;
   int          exp_en  = 0;
   int          seen_en = 0;
   int          d_ack_cyc[$];
   int          f_ack_cyc[$];
   bit          order_q[$];
   bit          loaded = 1'b0;

   function automatic logic [63:0] pat(int i);
      return 64'h0123_4567_89AB_0000 ^ (64'(i) * 64'h0000_0001_9E37_79B9);
   endfunction

   function automatic void check(string name, logic [63:0] act, logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endfunction

   // Environment memory: one-cycle read latency behind mem_en.
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < MEM_WORDS; i++) tmem[i] <= pat(i);
         loaded <= 1'b1;
      end else if (bus.mem_en) begin
         if (bus.mem_we) tmem[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata      <= tmem[bus.mem_addr];
      end
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (bus.mem_we && !bus.mem_en) begin
         total++; bad++;
         $display("FAIL mem_we_qual: mem_we high without mem_en");
      end
      if (bus.d_ack && bus.f_ack) begin
         total++; bad++;
         $display("FAIL dual_ack: both acks high");
      end
      if (bus.mem_en) seen_en++;
      if (bus.d_ack) begin
         order_q.push_back(1'b1);
         d_ack_cyc.push_back(cyc);
         if (dq.size() == 0) begin
            total++; bad++;
            $display("FAIL d_ack_unexpected: got ack want none");
         end else begin
            e = dq.pop_front();
            check("d_err", 64'(bus.d_err), 64'(e.err));
            check("d_rdata", bus.d_rdata, e.rdata);
         end
      end
      if (bus.f_ack) begin
         order_q.push_back(1'b0);
         f_ack_cyc.push_back(cyc);
         if (fq.size() == 0) begin
            total++; bad++;
            $display("FAIL f_ack_unexpected: got ack want none");
         end else begin
            e = fq.pop_front();
            check("f_err", 64'(bus.f_err), 64'(e.err));
            check("f_rdata", bus.f_rdata, e.rdata);
         end
      end
   end

   function automatic void push_d(bit we, logic [63:0] a, logic [63:0] wd);
      exp_t e;
      e.err = (a >= 64'(MEM_WORDS));
      if (!e.err) begin
         exp_en++;
         if (we) ref_mem[a[AW-1:0]] = wd;
         else    last_d = ref_mem[a[AW-1:0]];
      end
      e.rdata = last_d;
      dq.push_back(e);
   endfunction

   function automatic void push_f(logic [63:0] a);
      exp_t e;
      e.err = (a >= 64'(MEM_WORDS));
      if (!e.err) begin
         exp_en++;
         last_f = ref_mem[a[AW-1:0]];
      end
      e.rdata = last_f;
      fq.push_back(e);
   endfunction

   // Called just after a posedge; returns edges from request to observed ack.
   task automatic d_access(input bit we, input logic [63:0] a, input logic [63:0] wd, output int lat);
      bit seen = 1'b0;
      push_d(we, a, wd);
      bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd; bus.d_req = 1'b1;
      lat = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); lat++;
         @(negedge clk);
         if (bus.d_ack) seen = 1'b1;
      end
      if (!seen) begin
         total++; bad++;
         $display("FAIL d_timeout: no d_ack within 40 cycles for addr %h", a);
      end
      @(posedge clk); #1;
      bus.d_req = 1'b0;
   endtask

   task automatic f_access(input logic [63:0] a, output int lat);
      bit seen = 1'b0;
      push_f(a);
      bus.f_addr = a; bus.f_req = 1'b1;
      lat = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); lat++;
         @(negedge clk);
         if (bus.f_ack) seen = 1'b1;
      end
      if (!seen) begin
         total++; bad++;
         $display("FAIL f_timeout: no f_ack within 40 cycles for addr %h", a);
      end
      @(posedge clk); #1;
      bus.f_req = 1'b0;
   endtask

   // Holds D (addr 10) and/or F (addr 4100) requests high for nd / nf back-to-back reads.
   task automatic hold(input int nd, input int nf);
      int dc = 0;
      int fc = 0;
      int n  = 0;
      order_q.delete(); d_ack_cyc.delete(); f_ack_cyc.delete();
      for (int i = 0; i < nd; i++) push_d(1'b0, 64'd10, 64'd0);
      for (int i = 0; i < nf; i++) push_f(64'd4100);
      bus.d_we = 1'b0; bus.d_addr = 64'd10; bus.f_addr = 64'd4100;
      bus.d_req = (nd > 0); bus.f_req = (nf > 0);
      while ((dc < nd || fc < nf) && n < 200) begin
         @(negedge clk);
         if (bus.d_ack) dc++;
         if (bus.f_ack) fc++;
         @(posedge clk); #1;
         if (dc >= nd) bus.d_req = 1'b0;
         if (fc >= nf) bus.f_req = 1'b0;
         n++;
      end
      if (dc < nd || fc < nf) begin
         total++; bad++;
         $display("FAIL hold_timeout: d acks %0d/%0d f acks %0d/%0d", dc, nd, fc, nf);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int lat, lat_d, lat_f, en0;
      for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = pat(i);
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.f_req = 1'b0; bus.f_addr = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_d_ack",   64'(bus.d_ack),  64'd0);
      check("rst_f_ack",   64'(bus.f_ack),  64'd0);
      check("rst_mem_en",  64'(bus.mem_en), 64'd0);
      check("rst_busy",    64'(bus.busy),   64'd0);
      check("rst_d_rdata", bus.d_rdata,     64'd0);
      check("rst_f_rdata", bus.f_rdata,     64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Simultaneous first requests after reset: D first, F four cycles later.
      d_ack_cyc.delete(); f_ack_cyc.delete();
      fork
         d_access(1'b0, 64'd10, 64'd0, lat_d);
         f_access(64'd4100, lat_f);
      join
      check("tie_d_lat", 64'(lat_d), 64'd3);
      check("tie_f_lat", 64'(lat_f), 64'd7);
      if (d_ack_cyc.size() > 0 && f_ack_cyc.size() > 0)
         check("tie_gap", 64'(f_ack_cyc[0] - d_ack_cyc[0]), 64'd4);

      // Both held: grants alternate, D first since F was served last.
      hold(4, 4);
      check("alt_count", 64'(order_q.size()), 64'd8);
      for (int i = 0; i < order_q.size() && i < 8; i++)
         check("alt_order", 64'(order_q[i]), 64'((i % 2) == 0));

      // F alone held for three accesses: acks four cycles apart.
      hold(0, 3);
      check("f_hold_count", 64'(f_ack_cyc.size()), 64'd3);
      for (int i = 1; i < f_ack_cyc.size(); i++)
         check("f_hold_gap", 64'(f_ack_cyc[i] - f_ack_cyc[i-1]), 64'd4);

      en0 = seen_en;
      d_access(1'b1, 64'd5, 64'hDEAD_BEEF, lat);
      check("wr_lat", 64'(lat), 64'd3);
      d_access(1'b0, 64'd5, 64'd0, lat);
      check("rd_lat", 64'(lat), 64'd3);
      check("wr_rd_data", bus.d_rdata, 64'hDEAD_BEEF);
      check("wr_rd_en_pulses", 64'(seen_en - en0), 64'd2);

      en0 = seen_en;
      d_access(1'b0, 64'd8192, 64'd0, lat);
      check("d_oor_lat", 64'(lat), 64'd1);
      check("d_oor_no_en", 64'(seen_en - en0), 64'd0);
      d_access(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h55, lat);
      check("d_ones_lat", 64'(lat), 64'd1);
      check("d_ones_no_en", 64'(seen_en - en0), 64'd0);
      d_access(1'b0, 64'd8191, 64'd0, lat);
      check("d_top_lat", 64'(lat), 64'd3);

      f_access(64'hFFFF_FFFF_FFFF_FFFF, lat);
      check("f_oor_lat", 64'(lat), 64'd1);
      f_access(64'd0, lat);
      check("f_zero_lat", 64'(lat), 64'd3);

      // Reset during the ISSUE cycle of a D write aborts it.
      bus.d_we = 1'b1; bus.d_addr = 64'd7; bus.d_wdata = 64'h1234_5678; bus.d_req = 1'b1;
      @(posedge clk); #2;
      check("issue_mem_en", 64'(bus.mem_en), 64'd1);
      check("issue_mem_we", 64'(bus.mem_we), 64'd1);
      rst_n = 1'b0;
      #1;
      check("abort_mem_en",  64'(bus.mem_en), 64'd0);
      check("abort_mem_we",  64'(bus.mem_we), 64'd0);
      check("abort_busy",    64'(bus.busy),   64'd0);
      check("abort_d_ack",   64'(bus.d_ack),  64'd0);
      check("abort_d_rdata", bus.d_rdata,     64'd0);
      check("abort_f_rdata", bus.f_rdata,     64'd0);
      bus.d_req = 1'b0;
      last_d = '0; last_f = '0;
      @(negedge clk); @(negedge clk);
      check("abort_mem_word", tmem[7], ref_mem[7]);
      rst_n = 1'b1;
      @(posedge clk); #1;
      d_access(1'b0, 64'd7, 64'd0, lat);
      check("post_rst_lat", 64'(lat), 64'd3);

      // Random concurrent traffic: D owns words 0..63, F reads words 4096..4159.
      fork
         begin
            for (int k = 0; k < 30; k++) begin
               logic [63:0] a;
               int n;
               int r = int'($urandom_range(0, 9));
               if (r == 0)      a = 64'd8192 + 64'($urandom_range(0, 1000));
               else if (r == 1) a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
               else             a = 64'($urandom_range(0, 63));
               d_access(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, lat_d);
               check("d_rr_bound", 64'(lat_d <= 7), 64'd1);
               n = int'($urandom_range(0, 3));
               if (n > 0) begin repeat (n) @(posedge clk); #1; end
            end
         end
         begin
            for (int k = 0; k < 30; k++) begin
               logic [63:0] a;
               int n;
               if ($urandom_range(0, 7) == 0) a = 64'd8192 + 64'($urandom);
               else                           a = 64'd4096 + 64'($urandom_range(0, 63));
               f_access(a, lat_f);
               check("f_rr_bound", 64'(lat_f <= 7), 64'd1);
               n = int'($urandom_range(0, 3));
               if (n > 0) begin repeat (n) @(posedge clk); #1; end
            end
         end
      join

      repeat (4) @(posedge clk);
      @(negedge clk);
      check("d_queue_empty", 64'(dq.size()), 64'd0);
      check("f_queue_empty", 64'(fq.size()), 64'd0);
      check("mem_en_total", 64'(seen_en), 64'(exp_en));
      check("final_idle", 64'(bus.busy), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
